// File: rtl/cpu_sequencer.sv
// Instruction-cycle sequencer: fetch, IR load, decode, variable-length execute with memory stalls.
// Optional macro SEQ_SINGLE_STEP_EN adds in_step_pulse for one-instruction-per-pulse stepping.
module cpu_sequencer #(
    parameter int unsigned STEP_W    = 3,
    parameter int unsigned MAX_STEPS = 6,
    parameter int unsigned WAIT_MAX  = 15,
    parameter int unsigned INSTRET_W = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_run,
    input  logic [STEP_W-1:0]    in_step_count,
    input  logic                 in_halt_op,
    input  logic                 in_mem_req,
    input  logic                 in_mem_ready,
`ifdef SEQ_SINGLE_STEP_EN
    input  logic                 in_step_pulse,
`endif
    output logic [2:0]           out_state,
    output logic [STEP_W-1:0]    out_step,
    output logic                 out_step_en,
    output logic                 out_ir_load,
    output logic                 out_pc_inc,
    output logic                 out_busy,
    output logic [INSTRET_W-1:0] out_instret,
    output logic                 out_fault
);

    localparam int unsigned WAIT_W = $clog2(WAIT_MAX + 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        FETCH   = 3'd1,
        LOAD_IR = 3'd2,
        DECODE  = 3'd3,
        EXEC    = 3'd4,
        HALT    = 3'd5,
        FAULT   = 3'd6
    } state_t;

    state_t                 state_q, state_d;
    logic [STEP_W-1:0]      step_q, step_d;
    logic [STEP_W-1:0]      n_q, n_d;
    logic [WAIT_W-1:0]      wait_q, wait_d;
    logic [INSTRET_W-1:0]   instret_q, instret_d;
    logic                   halt_armed_q, halt_armed_d;
    logic                   strobe_q, busy_q, fault_q;
    logic                   stall_c;
    logic                   step_done_c;
    logic                   start_c;
    state_t                 after_retire_c;
    logic [STEP_W-1:0]      n_clamp_c;

    assign stall_c   = in_mem_req && !in_mem_ready;
    assign n_clamp_c = (in_step_count > STEP_W'(MAX_STEPS)) ? STEP_W'(MAX_STEPS) : in_step_count;

`ifdef SEQ_SINGLE_STEP_EN
    assign start_c        = in_run && in_step_pulse;
    assign after_retire_c = IDLE;
`else
    assign start_c        = in_run;
    assign after_retire_c = in_run ? FETCH : IDLE;
`endif

    // Next-state, step tracking, stall timeout and retire counting
    always_comb begin
        state_d      = state_q;
        step_d       = step_q;
        n_d          = n_q;
        wait_d       = wait_q;
        instret_d    = instret_q;
        halt_armed_d = halt_armed_q;
        step_done_c  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start_c) state_d = FETCH;
            end
            FETCH:   state_d = LOAD_IR;
            LOAD_IR: state_d = DECODE;
            DECODE: begin
                n_d    = n_clamp_c;
                step_d = '0;
                wait_d = '0;
                if (in_halt_op) begin
                    state_d      = HALT;
                    instret_d    = instret_q + INSTRET_W'(1);
                    halt_armed_d = 1'b0;
                end else if (n_clamp_c == '0) begin
                    state_d   = after_retire_c;
                    instret_d = instret_q + INSTRET_W'(1);
                end else begin
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (!stall_c) begin
                    step_done_c = 1'b1;
                    wait_d      = '0;
                    if (step_q == n_q - STEP_W'(1)) begin
                        step_d    = '0;
                        state_d   = after_retire_c;
                        instret_d = instret_q + INSTRET_W'(1);
                    end else begin
                        step_d = step_q + STEP_W'(1);
                    end
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                    // This stall cycle is the WAIT_MAX-th in a row: give up
                    if (wait_q == WAIT_W'(WAIT_MAX - 1)) begin
                        state_d = FAULT;
                        step_d  = '0;
                    end
                end
            end
            HALT: begin
                if (!in_run) begin
                    halt_armed_d = 1'b1;
                end else if (halt_armed_q) begin
                    state_d = FETCH;
                end
            end
            FAULT:   state_d = FAULT;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            step_q       <= '0;
            n_q          <= '0;
            wait_q       <= '0;
            instret_q    <= '0;
            halt_armed_q <= 1'b0;
            strobe_q     <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            step_q       <= step_d;
            n_q          <= n_d;
            wait_q       <= wait_d;
            instret_q    <= instret_d;
            halt_armed_q <= halt_armed_d;
            strobe_q     <= (state_d == LOAD_IR);
            busy_q       <= (state_d == FETCH) || (state_d == LOAD_IR) ||
                            (state_d == DECODE) || (state_d == EXEC);
            fault_q      <= (state_d == FAULT);
        end
    end

    // Step completion depends on same-cycle memory ready, so it is combinational by nature
    assign out_step_en = step_done_c;
    assign out_state   = state_q;
    assign out_step    = step_q;
    assign out_ir_load = strobe_q;
    assign out_pc_inc  = strobe_q;
    assign out_busy    = busy_q;
    assign out_instret = instret_q;
    assign out_fault   = fault_q;

endmodule
